// File: rtl/gpu_task_scheduler.sv
// rtl/gpu_task_scheduler.sv - Kernel program buffer and serial launcher feeding the gpu_core array.
module gpu_task_scheduler #(
    parameter int N_CORES    = 4,
    parameter int PROG_DEPTH = 16,
    parameter int INS_W      = 16,
    localparam int AW        = $clog2(PROG_DEPTH),
    localparam int CW        = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_wr_en,
    input  logic [AW-1:0]      host_wr_addr,
    input  logic [INS_W-1:0]   host_wr_data,
    input  logic               start,
    input  logic [N_CORES-1:0] core_mask,
    input  logic [N_CORES-1:0] core_rtr,
    input  logic [N_CORES-1:0] core_ready,
    output logic [N_CORES-1:0] val_ins,
    output logic [INS_W-1:0]   instruction,
    output logic               busy,
    output logic               done,
    output logic [N_CORES-1:0] done_mask,
    output logic [CW-1:0]      cur_core
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [AW-1:0]      FIRST_WORD = '0;
    localparam logic [AW-1:0]      LAST_WORD  = AW'(PROG_DEPTH - 1);
    localparam logic [N_CORES-1:0] ONE_HOT0   = N_CORES'(1);

    state_t               state_q, state_d;
    logic [N_CORES-1:0]   pend_q, pend_d;
    logic [N_CORES-1:0]   launched_q, launched_d;
    logic [N_CORES-1:0]   armed_q, armed_d;
    logic [N_CORES-1:0]   done_mask_q, done_mask_d;
    logic [N_CORES-1:0]   val_ins_q, val_ins_d;
    logic [INS_W-1:0]     instruction_q, instruction_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cur_core_q, cur_core_d;
    logic [INS_W-1:0]     prog_q [PROG_DEPTH];
    logic [INS_W-1:0]     prog_d [PROG_DEPTH];

    logic                 sel_found;
    logic [CW-1:0]        sel_idx;
    logic [N_CORES-1:0]   ready_hit;
    logic                 all_done;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        launched_d    = launched_q;
        armed_d       = armed_q;
        done_mask_d   = done_mask_q;
        val_ins_d     = val_ins_q;
        instruction_d = instruction_q;
        cnt_d         = cnt_q;
        cur_core_d    = cur_core_q;
        prog_d        = prog_q;

        all_done  = (done_mask_q == launched_q);
        ready_hit = armed_q & core_ready;

        // Lowest-index pending core that is ready to receive wins.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (pend_q[i] && core_rtr[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
            end
        end

        if (host_wr_en && (state_q == S_IDLE)) begin
            prog_d[host_wr_addr] = host_wr_data;
        end

        // Ready only counts once a core has been fully loaded, hiding its stale level.
        if (state_q != S_IDLE) begin
            done_mask_d = done_mask_q | ready_hit;
            armed_d     = armed_q & ~ready_hit;
        end

        case (state_q)
            S_IDLE: begin
                if (start && (core_mask != '0)) begin
                    pend_d      = core_mask;
                    launched_d  = core_mask;
                    armed_d     = '0;
                    done_mask_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pend_q == '0) begin
                    state_d = S_WAIT;
                end else if (sel_found) begin
                    cur_core_d    = sel_idx;
                    cnt_d         = '0;
                    val_ins_d     = ONE_HOT0 << sel_idx;
                    instruction_d = prog_q[FIRST_WORD];
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == LAST_WORD) begin
                    pend_d        = pend_q & ~val_ins_q;
                    armed_d       = armed_d | val_ins_q;
                    val_ins_d     = '0;
                    instruction_d = '0;
                    cur_core_d    = '0;
                    state_d       = S_SELECT;
                end else begin
                    cnt_d         = cnt_q + 1'b1;
                    instruction_d = prog_q[cnt_q + 1'b1];
                end
            end
            S_WAIT: begin
                if (all_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            launched_q    <= '0;
            armed_q       <= '0;
            done_mask_q   <= '0;
            val_ins_q     <= '0;
            instruction_q <= '0;
            cnt_q         <= '0;
            cur_core_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            launched_q    <= launched_d;
            armed_q       <= armed_d;
            done_mask_q   <= done_mask_d;
            val_ins_q     <= val_ins_d;
            instruction_q <= instruction_d;
            cnt_q         <= cnt_d;
            cur_core_q    <= cur_core_d;
        end
    end

    // Program words survive reset so a relaunch after reset resends the same kernel.
    always_ff @(posedge clk) begin
        prog_q <= prog_d;
    end

    assign val_ins     = val_ins_q;
    assign instruction = instruction_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_WAIT) && all_done;
    assign done_mask   = done_mask_q;
    assign cur_core    = cur_core_q;

endmodule

// File: doc/gpu_task_scheduler.md
Name: gpu_task_scheduler

Overview:
- Upstream feeder for the gpu_core array.
- Holds one 16-word kernel program written by the host. On start, it streams the program serially into each selected core over the val_ins/rtr/instruction handshake.
- It then watches each core's ready line and reports completion of the whole launch back to the host.

Parameters:
- N_CORES, 4, number of cores served; one val_ins/rtr/ready triple per core.
- PROG_DEPTH, 16, program words per kernel. Must equal the core instruction memory depth.
- INS_W, 16, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_wr_en  in  1  program buffer write strobe.
- host_wr_addr  in  4  program buffer word address.
- host_wr_data  in  INS_W  program word.
- start  in  1  launch request, sampled in IDLE.
- core_mask  in  N_CORES  cores to launch on; sampled with start.
- core_rtr  in  N_CORES  per-core ready-to-receive.
- core_ready  in  N_CORES  per-core kernel-finished level.
- val_ins  out  N_CORES  per-core instruction-valid, one-hot or zero.
- instruction  out  INS_W  shared instruction bus to all cores.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all launched cores have finished.
- done_mask  out  N_CORES  cores finished in the current or last launch.
- cur_core  out  2  index of the core being fed; 0 when not in SEND.

Behaviour:
- Reset values (async): val_ins=0, instruction=0, busy=0, done=0, done_mask=0, cur_core=0, state=IDLE, launch mask=0, word counter=0.
  - The program buffer is NOT reset.
  - Reset mid-SEND drops val_ins immediately. The partially loaded core is left to the system-level reset.
- Program buffer: PROG_DEPTH x INS_W registers.
  - Written on host_wr_en only in IDLE; writes in any other state are ignored.
  - A write and a start in the same IDLE cycle: the write lands first and start still launches, so the new word is sent.
- State IDLE:
  - start=1 with core_mask!=0: latch pend=core_mask and launched=core_mask, clear done_mask, go to SELECT.
  - start with core_mask=0 is ignored.
  - start in any other state is ignored.
- State SELECT:
  - Choose the lowest index k with pend[k]=1 and core_rtr[k]=1, load cur_core=k, clear the word counter, go to SEND.
  - If pend has bits set but no corresponding rtr is high, stay in SELECT; higher-index ready cores are still eligible.
  - pend==0: go to WAIT.
- State SEND (exactly PROG_DEPTH cycles per core):
  - Each cycle: val_ins[k]=1, instruction=prog[cnt], cnt++.
  - The first val_ins cycle is the cycle after the SELECT decision, with registered outputs.
  - core_rtr is not re-checked inside SEND. The core is required to hold rtr until it has taken 16 words.
  - After the word with cnt=15: clear pend[k], set armed[k], then val_ins=0 and instruction=0 next cycle; go to SELECT.
  - No idle cycle is inserted beyond the SELECT cycle.
- Completion, sampled in SELECT, SEND and WAIT:
  - done_mask[j] is set when armed[j]=1 and core_ready[j]=1.
  - ready is ignored before the core's last word is sent. This masks the stale ready level left from a previous kernel, which the core clears on its first val_ins.
  - armed[j] clears when done_mask[j] sets.
- State WAIT: when done_mask==launched, pulse done for exactly one cycle, then go to IDLE.
- done_mask holds its value in IDLE until the next accepted start.
- Simultaneous events: a core finishing in the same cycle another core's last word is sent is recorded; both updates apply.

Test Plan:
- Reset, then write prog[i]=16'h1000+i for i=0..15; start with core_mask=4'b0001, core_rtr=4'b1111 -> val_ins=4'b0001 for 16 consecutive cycles, instruction 16'h1000..16'h100F in order, busy=1.
  - Then drive core_ready[0]=1 -> done pulses 1 cycle, done_mask=4'b0001, busy=0 next cycle.
- core_mask=4'b1010 -> core 1 fed first (cur_core=1), then core 3.
  - Core 3's 16 words start 1 cycle after core 1's last.
  - done fires only after both core_ready[1] and core_ready[3] have gone high, in either order.
- core_mask=4'b0011 with core_rtr[0]=0 for 40 cycles, core_rtr[1]=1 -> core 1 fed first.
  - Core 0 is fed once its rtr rises.
  - No val_ins on core 0 before that.
- core_ready[0] held 1 from before the launch -> done_mask[0] stays 0 throughout SEND.
  - done_mask[0] sets only on a core_ready[0] level sampled after word 15 is sent.
- host_wr_en to addr 3 while busy=1 -> prog[3] unchanged on the next launch.
  - start while busy is ignored, with no second done pulse.
  - start with core_mask=0 in IDLE leaves busy=0.
- reset asserted at SEND word 7 -> val_ins=0, busy=0, done_mask=0 immediately.
  - The program buffer contents are retained and the next launch sends the identical words.
